rect_draw_engine: RTL

//  Command-driven rectangle rasteriser placed directly upstream of vga_adapter.

---
 rtl/rect_draw_engine_pkg.sv | 27 ++
 rtl/rect_draw_engine_up_count.sv | 36 +++
 rtl/rect_draw_engine.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rect_draw_engine_pkg.sv
// Shared widths, screen limits, FSM encoding and the outline test for the
// rectangle rasteriser.
package rect_draw_engine_pkg;

  localparam int NX = 10;
  localparam int NY = 9;
  localparam int NC = 9;

  localparam logic [NX:0]   X_MAX = 11'd640;
  localparam logic [NY:0]   Y_MAX = 10'd480;
  localparam logic [NX-1:0] X_ONE = 10'd1;
  localparam logic [NY-1:0] Y_ONE = 9'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True when the scan position lies on the rectangle border.
  function automatic logic on_border(input logic [NX-1:0] xc, input logic [NY-1:0] yc,
                                     input logic [NX-1:0] w,  input logic [NY-1:0] h);
    return (xc == {NX{1'b0}}) || (xc == w - X_ONE) ||
           (yc == {NY{1'b0}}) || (yc == h - Y_ONE);
  endfunction

endpackage

// File: rtl/rect_draw_engine_up_count.sv
// Loadable up-counter with enable; load takes priority over enable.
module rect_draw_engine_up_count #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         enable,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (enable) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rect_draw_engine.sv
// Command-driven rectangle rasteriser: one pixel position per clock in raster
// order, with screen clipping and optional outline-only mode.
module rect_draw_engine
  import rect_draw_engine_pkg::*;
(
  input  logic          Clock,
  input  logic          Reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [NX-1:0] cmd_x,
  input  logic [NY-1:0] cmd_y,
  input  logic [NX-1:0] cmd_w,
  input  logic [NY-1:0] cmd_h,
  input  logic [NC-1:0] cmd_color,
  input  logic          cmd_outline,
  output logic [NX-1:0] pix_x,
  output logic [NY-1:0] pix_y,
  output logic [NC-1:0] pix_color,
  output logic          pix_write,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [NX-1:0] x0_q, x0_d, w_q, w_d;
  logic [NY-1:0] y0_q, y0_d, h_q, h_d;
  logic [NC-1:0] color_q, color_d;
  logic          outline_q, outline_d;
  logic [NX-1:0] pix_x_q, pix_x_d;
  logic [NY-1:0] pix_y_q, pix_y_d;
  logic [NC-1:0] pix_color_q, pix_color_d;
  logic [NX-1:0] xc;
  logic [NY-1:0] yc;
  logic [NX:0]   sum_x;
  logic [NY:0]   sum_y;
  logic          accept, empty, in_draw, x_last, y_last, wrap;

  assign in_draw = (state_q == ST_DRAW);
  assign accept  = cmd_valid && (state_q == ST_IDLE);
  assign empty   = (cmd_w == {NX{1'b0}}) || (cmd_h == {NY{1'b0}});
  assign x_last  = (xc == w_q - X_ONE);
  assign y_last  = (yc == h_q - Y_ONE);
  assign wrap    = in_draw && x_last;

  rect_draw_engine_up_count #(.W(NX)) u_xc (
    .clk      (Clock),
    .reset    (Reset),
    .load     (accept || wrap),
    .enable   (in_draw),
    .load_val ({NX{1'b0}}),
    .count    (xc)
  );

  rect_draw_engine_up_count #(.W(NY)) u_yc (
    .clk      (Clock),
    .reset    (Reset),
    .load     (accept),
    .enable   (wrap),
    .load_val ({NY{1'b0}}),
    .count    (yc)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = empty ? ST_DONE : ST_DRAW;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAW: begin
        if (x_last && y_last) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAW;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    x0_d      = x0_q;
    y0_d      = y0_q;
    w_d       = w_q;
    h_d       = h_q;
    color_d   = color_q;
    outline_d = outline_q;
    if (accept) begin
      x0_d      = cmd_x;
      y0_d      = cmd_y;
      w_d       = cmd_w;
      h_d       = cmd_h;
      color_d   = cmd_color;
      outline_d = cmd_outline;
    end else begin
      outline_d = outline_q;
    end
  end

  // Clip on the untruncated sums; the truncated sums still go out on pix_x/pix_y.
  always_comb begin
    sum_x       = {1'b0, x0_q} + {1'b0, xc};
    sum_y       = {1'b0, y0_q} + {1'b0, yc};
    pix_write   = 1'b0;
    pix_x_d     = pix_x_q;
    pix_y_d     = pix_y_q;
    pix_color_d = pix_color_q;
    if (in_draw) begin
      pix_x_d     = sum_x[NX-1:0];
      pix_y_d     = sum_y[NY-1:0];
      pix_color_d = color_q;
      pix_write   = (sum_x < X_MAX) && (sum_y < Y_MAX) &&
                    (!outline_q || on_border(xc, yc, w_q, h_q));
    end else begin
      pix_write   = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      x0_q        <= {NX{1'b0}};
      y0_q        <= {NY{1'b0}};
      w_q         <= {NX{1'b0}};
      h_q         <= {NY{1'b0}};
      color_q     <= {NC{1'b0}};
      outline_q   <= 1'b0;
      pix_x_q     <= {NX{1'b0}};
      pix_y_q     <= {NY{1'b0}};
      pix_color_q <= {NC{1'b0}};
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      color_q     <= color_d;
      outline_q   <= outline_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
    end
  end

  assign pix_x     = pix_x_d;
  assign pix_y     = pix_y_d;
  assign pix_color = pix_color_d;
  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_DRAW) || (state_q == ST_DONE);
  assign done      = (state_q == ST_DONE);

endmodule
